// File: rtl/cc_pkg.sv
// Shared cache-controller constants and types for the hit serializer and fill deserializer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cc_pkg;

   localparam int CC_BEAT_W = 64;
   localparam int CC_BEATS  = 8;
   localparam int CC_OFS_W  = 3;
   localparam int CC_LINE_W = 512;

   typedef logic [CC_LINE_W-1:0] line_t;
   typedef logic [CC_BEAT_W-1:0] beat_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/cc_beat_mux.sv
// Picks one beat of a line: word (offset + cnt) with natural wrap inside the line.
// Latency: purely combinational.
// Backpressure: none; the caller holds offset/cnt stable while a beat is stalled.
module cc_beat_mux
   import cc_pkg::*;
#(
   parameter int BEAT_W = CC_BEAT_W,
   parameter int BEATS  = CC_BEATS,
   parameter int OFS_W  = CC_OFS_W
) (
   input  logic [BEAT_W*BEATS-1:0] line,
   input  logic [OFS_W-1:0]        offset,
   input  logic [OFS_W-1:0]        cnt,
   output logic [BEAT_W-1:0]       beat
);

   logic [OFS_W-1:0] ptr;

   // Wrap by truncating the sum to OFS_W bits, then slice out the selected word.
   always_comb begin
      ptr  = offset + cnt;
      beat = line[ptr*BEAT_W +: BEAT_W];
   end

endmodule

// File: rtl/cc_line_serializer.sv
// Streams one cache line as a critical-word-first, wrapping 8-beat R burst.
// Latency: first beat valid the cycle after the line is accepted; back-to-back lines with no gap.
// Backpressure: rready low holds the current beat; a new line is accepted only when idle or on the last-beat handshake.
module cc_line_serializer
   import cc_pkg::*;
#(
   parameter int BEAT_W = CC_BEAT_W,
   parameter int BEATS  = CC_BEATS,
   parameter int OFS_W  = CC_OFS_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    line_valid_i,
   output logic                    line_ready_o,
   input  logic [BEAT_W*BEATS-1:0] line_data_i,
   input  logic [OFS_W-1:0]        line_offset_i,
   output logic [BEAT_W-1:0]       rdata_o,
   output logic                    rvalid_o,
   output logic                    rlast_o,
   input  logic                    rready_i,
   output logic                    busy_o
);

   localparam logic [OFS_W-1:0] CNT_LAST = OFS_W'(BEATS - 1);

   ser_state_t               state;
   ser_state_t               state_nxt;
   logic [BEAT_W*BEATS-1:0]  line_q;
   logic [OFS_W-1:0]         ofs_q;
   logic [OFS_W-1:0]         cnt_q;
   logic [BEAT_W-1:0]        beat;
   logic                     beat_hs;
   logic                     last_hs;
   logic                     accept;

   cc_beat_mux #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS),
      .OFS_W  (OFS_W)
   ) u_mux (
      .line   (line_q),
      .offset (ofs_q),
      .cnt    (cnt_q),
      .beat   (beat)
   );

   // Outputs decode straight from state so an async reset drops them immediately;
   // line_ready is combinational from rready to allow a zero-bubble reload.
   always_comb begin
      state_nxt    = state;
      rvalid_o     = (state == SEND);
      rlast_o      = (state == SEND) && (cnt_q == CNT_LAST);
      rdata_o      = (state == SEND) ? beat : '0;
      busy_o       = (state == SEND);
      beat_hs      = rvalid_o && rready_i;
      last_hs      = beat_hs && rlast_o;
      line_ready_o = (state == IDLE) || last_hs;
      accept       = line_valid_i && line_ready_o;
      case (state)
         IDLE:    if (accept)  state_nxt = SEND;
         SEND:    if (last_hs) state_nxt = accept ? SEND : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Beat counter restarts on every accepted line and after the final beat; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt_q <= '0;
      else if (accept || last_hs)   cnt_q <= '0;
      else if (beat_hs)             cnt_q <= cnt_q + 1'b1;
   end

   // Line buffer and start offset are captured only when a line is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
         ofs_q  <= '0;
      end else if (accept) begin
         line_q <= line_data_i;
         ofs_q  <= line_offset_i;
      end
   end

endmodule

// File: tb/tb_cc_line_serializer.sv
// Directed bench for the line serializer: ordering, wrap, stalls, back-to-back, reset.
// Latency: n/a.
// Backpressure: rready patterns are driven per test.
module tb_cc_line_serializer;
   import cc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line_valid;
   logic       line_ready;
   line_t      line_data;
   logic [2:0] line_offset;
   beat_t      rdata;
   logic       rvalid;
   logic       rlast;
   logic       rready;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Beats observed by run_burst: every valid cycle, and the handshaken subset.
   beat_t s_dat[$];
   logic  s_last[$];
   logic  s_hs[$];
   beat_t h_dat[$];
   logic  h_last[$];
   int    gaps;
   int    hs_cnt;

   always #5 clk = ~clk;

   cc_line_serializer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .line_valid_i  (line_valid),
      .line_ready_o  (line_ready),
      .line_data_i   (line_data),
      .line_offset_i (line_offset),
      .rdata_o       (rdata),
      .rvalid_o      (rvalid),
      .rlast_o       (rlast),
      .rready_i      (rready),
      .busy_o        (busy)
   );

   function automatic line_t mk_line(input logic [31:0] tag);
      line_t l;
      for (int k = 0; k < 8; k++) l[64*k +: 64] = {tag, 32'(k)};
      return l;
   endfunction

   function automatic beat_t wd(input logic [31:0] tag, input int k);
      return {tag, 32'(k)};
   endfunction

   // Offers one line from an idle DUT, then records beats until 8 handshakes or a cycle budget.
   // rready is held low for slen cycles before beats sa and sb.
   task automatic run_burst(input line_t ln, input logic [2:0] ofs,
                            input int sa, input int sb, input int slen);
      logic pat[$];
      int   cyc;
      for (int b = 0; b < 8; b++) begin
         if (b == sa || b == sb)
            for (int s = 0; s < slen; s++) pat.push_back(1'b0);
         pat.push_back(1'b1);
      end
      s_dat.delete(); s_last.delete(); s_hs.delete();
      h_dat.delete(); h_last.delete();
      gaps = 0; hs_cnt = 0;
      line_valid = 1'b1; line_data = ln; line_offset = ofs; rready = 1'b1;
      @(posedge clk); #1;
      line_valid = 1'b0;
      cyc = 0;
      while (hs_cnt < 8 && cyc < 64) begin
         rready = (cyc < pat.size()) ? pat[cyc] : 1'b1;
         #1;
         if (!rvalid) gaps++;
         else begin
            s_dat.push_back(rdata); s_last.push_back(rlast); s_hs.push_back(rready);
            if (rready) begin
               h_dat.push_back(rdata); h_last.push_back(rlast); hs_cnt++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; line_valid = 1'b0; line_data = '0; line_offset = '0; rready = 1'b1;
      #12;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
      checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got %0b want 0", rlast); end
      checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL reset_line_ready got %0b want 1", line_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release got %0b want 0", busy); end
   endtask

   task automatic test_in_order();
      run_burst(mk_line(32'hA0A0_0000), 3'd0, -1, -1, 0);
      checks++; if (hs_cnt !== 8) begin errors++; $display("FAIL order0_handshakes got %0d want 8", hs_cnt); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL order0_gaps got %0d want 0", gaps); end
      for (int i = 0; i < h_dat.size(); i++) begin
         checks++; if (h_dat[i] !== wd(32'hA0A0_0000, i)) begin errors++; $display("FAIL order0_data beat %0d got %h want %h", i, h_dat[i], wd(32'hA0A0_0000, i)); end
         checks++; if (h_last[i] !== (i == 7)) begin errors++; $display("FAIL order0_rlast beat %0d got %0b want %0b", i, h_last[i], (i == 7)); end
      end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL order0_rvalid_after got %0b want 0", rvalid); end
      checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL order0_ready_after got %0b want 1", line_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order0_busy_after got %0b want 0", busy); end
   endtask

   task automatic test_offset_wrap();
      int exp_w[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
      run_burst(mk_line(32'hA0A0_0000), 3'd5, -1, -1, 0);
      checks++; if (hs_cnt !== 8) begin errors++; $display("FAIL wrap5_handshakes got %0d want 8", hs_cnt); end
      for (int i = 0; i < h_dat.size(); i++) begin
         checks++; if (h_dat[i] !== wd(32'hA0A0_0000, exp_w[i])) begin errors++; $display("FAIL wrap5_data beat %0d got %h want %h", i, h_dat[i], wd(32'hA0A0_0000, exp_w[i])); end
         checks++; if (h_last[i] !== (i == 7)) begin errors++; $display("FAIL wrap5_rlast beat %0d got %0b want %0b", i, h_last[i], (i == 7)); end
      end
   endtask

   task automatic test_stall();
      int exp_w[8] = '{2, 3, 4, 5, 6, 7, 0, 1};
      run_burst(mk_line(32'hA0A0_0000), 3'd2, 1, 6, 3);
      checks++; if (hs_cnt !== 8) begin errors++; $display("FAIL stall_handshakes got %0d want 8", hs_cnt); end
      checks++; if (s_dat.size() !== 14) begin errors++; $display("FAIL stall_valid_cycles got %0d want 14", s_dat.size()); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL stall_gaps got %0d want 0", gaps); end
      for (int j = 0; j + 1 < s_dat.size(); j++) begin
         if (!s_hs[j]) begin
            checks++; if (s_dat[j+1] !== s_dat[j]) begin errors++; $display("FAIL stall_hold_data cycle %0d got %h want %h", j + 1, s_dat[j+1], s_dat[j]); end
            checks++; if (s_last[j+1] !== s_last[j]) begin errors++; $display("FAIL stall_hold_rlast cycle %0d got %0b want %0b", j + 1, s_last[j+1], s_last[j]); end
         end
      end
      for (int i = 0; i < h_dat.size(); i++) begin
         checks++; if (h_dat[i] !== wd(32'hA0A0_0000, exp_w[i])) begin errors++; $display("FAIL stall_data beat %0d got %h want %h", i, h_dat[i], wd(32'hA0A0_0000, exp_w[i])); end
         checks++; if (h_last[i] !== (i == 7)) begin errors++; $display("FAIL stall_rlast beat %0d got %0b want %0b", i, h_last[i], (i == 7)); end
      end
   endtask

   task automatic test_back_to_back();
      int    exp_w[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 0, 1, 2, 3, 4, 5, 6};
      beat_t exp_d;
      line_valid = 1'b1; line_data = mk_line(32'hA0A0_0000); line_offset = 3'd0; rready = 1'b1;
      @(posedge clk); #1;
      line_data = mk_line(32'hB0B0_0000); line_offset = 3'd7;
      for (int i = 0; i < 16; i++) begin
         #1;
         exp_d = wd((i < 8) ? 32'hA0A0_0000 : 32'hB0B0_0000, exp_w[i]);
         checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid cycle %0d got %0b want 1", i, rvalid); end
         checks++; if (rdata !== exp_d) begin errors++; $display("FAIL b2b_data cycle %0d got %h want %h", i, rdata, exp_d); end
         checks++; if (rlast !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_rlast cycle %0d got %0b want %0b", i, rlast, (i == 7 || i == 15)); end
         checks++; if (line_ready !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_line_ready cycle %0d got %0b want %0b", i, line_ready, (i == 7 || i == 15)); end
         @(posedge clk); #1;
         if (i == 7) line_valid = 1'b0;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got %0b want 0", busy); end
   endtask

   task automatic test_reset_mid_burst();
      int exp_w[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
      line_valid = 1'b1; line_data = mk_line(32'hC0C0_0000); line_offset = 3'd3; rready = 1'b1;
      @(posedge clk); #1;
      line_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      checks++; if (rdata !== wd(32'hC0C0_0000, 6)) begin errors++; $display("FAIL rstmid_beat3_data got %h want %h", rdata, wd(32'hC0C0_0000, 6)); end
      rst_n = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %0b want 0", rvalid); end
      checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL rstmid_rlast got %0b want 0", rlast); end
      checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
      checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL rstmid_line_ready got %0b want 1", line_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after got %0b want 0", rvalid); end
      run_burst(mk_line(32'hD0D0_0000), 3'd1, -1, -1, 0);
      checks++; if (hs_cnt !== 8) begin errors++; $display("FAIL rstmid_handshakes got %0d want 8", hs_cnt); end
      for (int i = 0; i < h_dat.size(); i++) begin
         checks++; if (h_dat[i] !== wd(32'hD0D0_0000, exp_w[i])) begin errors++; $display("FAIL rstmid_data beat %0d got %h want %h", i, h_dat[i], wd(32'hD0D0_0000, exp_w[i])); end
         checks++; if (h_last[i] !== (i == 7)) begin errors++; $display("FAIL rstmid_rlast beat %0d got %0b want %0b", i, h_last[i], (i == 7)); end
      end
   endtask

   task automatic test_offer_during_send();
      int exp_w[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
      line_valid = 1'b1; line_data = mk_line(32'hE0E0_0000); line_offset = 3'd3; rready = 1'b1;
      @(posedge clk); #1;
      line_data = mk_line(32'hF0F0_0000); line_offset = 3'd4;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (rdata !== wd(32'hE0E0_0000, exp_w[i])) begin errors++; $display("FAIL offer_data beat %0d got %h want %h", i, rdata, wd(32'hE0E0_0000, exp_w[i])); end
         checks++; if (line_ready !== (i == 7)) begin errors++; $display("FAIL offer_line_ready beat %0d got %0b want %0b", i, line_ready, (i == 7)); end
         checks++; if (rlast !== (i == 7)) begin errors++; $display("FAIL offer_rlast beat %0d got %0b want %0b", i, rlast, (i == 7)); end
         @(posedge clk); #1;
      end
      line_valid = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL offer_second_rvalid got %0b want 1", rvalid); end
      checks++; if (rdata !== wd(32'hF0F0_0000, 4)) begin errors++; $display("FAIL offer_second_first got %h want %h", rdata, wd(32'hF0F0_0000, 4)); end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL offer_busy_after got %0b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_offset_wrap();
      test_stall();
      test_back_to_back();
      test_reset_mid_burst();
      test_offer_during_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cc_line_serializer.md
Name: cc_line_serializer

Overview:
- Read-hit return path of the cache controller, and the inverse of the miss-fill deserializer.
- Accepts one 512-bit cache line plus the requested 64-bit word offset from the hit-data path.
- Streams the line as an 8-beat AXI R-channel burst (64-bit beats) toward the requester, critical word first, wrapping within the line.
- Supports back-to-back lines with no idle cycle between bursts.

Parameters:
- BEAT_W, 64, width of one R beat in bits.
- BEATS, 8, beats per line; must be a power of two.
- OFS_W, 3, width of the word offset; equals log2(BEATS).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- line_valid_i  input  1  a line is offered
- line_ready_o  output  1  the block accepts the offered line this cycle
- line_data_i  input  BEAT_W*BEATS  line data; word k is at bits [64k+63:64k]
- line_offset_i  input  OFS_W  first word to send (from request address bits [5:3])
- rdata_o  output  BEAT_W  R-channel beat data
- rvalid_o  output  1  beat valid
- rlast_o  output  1  final beat of the burst
- rready_i  input  1  requester accepts the beat
- busy_o  output  1  a burst is in progress

Behaviour:
- Reset is asynchronous active-low and takes effect immediately.
- Reset values:
  - state = IDLE; beat counter = 0; line buffer = 0; offset register = 0.
  - rvalid_o = 0, rlast_o = 0, rdata_o = 0, busy_o = 0, line_ready_o = 1.
- State machine has two states, IDLE and SEND.
- Line accept:
  - Condition: line_valid_i && line_ready_o.
  - On accept, latch line_data_i and line_offset_i, clear the beat counter to 0, and go to SEND.
- line_ready_o = (state == IDLE) || (rvalid_o && rready_i && rlast_o).
  - This is combinational from rready_i, so a new line can be accepted on the last-beat handshake with zero bubble.
- Latency: the first beat is presented (rvalid_o = 1) on the cycle after the accepting edge.
- In SEND:
  - rvalid_o = 1.
  - ptr = (offset + cnt) mod BEATS, computed in OFS_W bits with natural wrap.
  - rdata_o = word[ptr] of the latched line.
  - rlast_o = (cnt == BEATS-1).
- A beat handshake (rvalid_o && rready_i) increments cnt by 1.
- rvalid_o && !rready_i: rdata_o, rlast_o and cnt hold stable. The AXI rule is that valid never drops before a handshake.
- Last-beat handshake:
  - If line_valid_i is also high, the new line is loaded, cnt = 0, and the block stays in SEND.
  - Otherwise it goes to IDLE and cnt = 0.
- In IDLE: rvalid_o = 0, rlast_o = 0, rdata_o = 0.
- busy_o = (state == SEND).
- line_valid_i while in SEND (not last handshake): line_ready_o = 0 and the line is not sampled. The upstream source holds it.
- Offset wrap example, offset 6: word order is 6, 7, 0, 1, 2, 3, 4, 5; rlast_o is on word 5.
- Reset mid-burst:
  - The burst is abandoned and rvalid_o drops asynchronously.
  - No partial-completion signalling.
  - The next accepted line starts a fresh 8-beat burst.
- A single line is never repeated or skipped. Exactly BEATS handshakes occur per accepted line.

Decomposition:
- Shared package cc_pkg holds:
  - Constants CC_BEAT_W = 64, CC_BEATS = 8, CC_OFS_W = 3, CC_LINE_W = 512.
  - typedef line_t (logic [511:0]).
  - typedef beat_t (logic [63:0]).
  - enum ser_state_t {IDLE, SEND}.
- The same package constants are reused by the fill deserializer.
- One sub-module is natural: cc_beat_mux.
  - Purely combinational 8:1 word select.
  - Inputs: line, offset, cnt. Output: beat.
  - Instantiated once.
- Everything else (FSM, counter, line buffer) lives in the top.

Test Plan:
- Line word k = 64'hA0A0_0000_0000_000k, offset 0, rready_i held 1 -> rvalid_o on cycles 1..8, rdata_o words 0..7 in order, rlast_o only on word 7, line_ready_o high again after burst.
- Same line, offset 5 -> beats carry words 5, 6, 7, 0, 1, 2, 3, 4; rlast_o with word 4; exactly 8 handshakes.
- Offset 2, rready_i low on beats 1 and 6 for 3 cycles each -> rdata_o and rlast_o unchanged during stall, order 2..7, 0, 1 preserved, no lost or duplicated beat.
- Two lines offered back-to-back (line_valid_i held), offsets 0 and 7 -> 16 consecutive handshake cycles with no rvalid_o gap; second burst starts with word 7; line_ready_o pulses high exactly on the last beat of burst 1.
- rst_n asserted asynchronously mid-clock after beat 3 of a burst -> rvalid_o, rlast_o and rdata_o go to 0 before the next edge; after release, a new line with offset 1 produces a full 8-beat burst starting at word 1.
- line_valid_i offered during SEND (not last beat) -> line_ready_o = 0, current burst unaffected, offered line accepted only on the last-beat handshake.
